// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - video mode table and derived timing constants for vga_timing_multimode
package vga_timing_pkg;

   typedef struct packed {
      logic [11:0] h_active;
      logic [11:0] h_fp;
      logic [11:0] h_sync;
      logic [11:0] h_bp;
      logic [10:0] v_active;
      logic [10:0] v_fp;
      logic [10:0] v_sync;
      logic [10:0] v_bp;
      logic        hpol;
      logic        vpol;
      logic [11:0] bar_w;
   } mode_t;

   typedef struct packed {
      logic [11:0] h_total;
      logic [11:0] hs_start;
      logic [11:0] hs_end;
      logic [11:0] h_last;
      logic [11:0] bar_last;
      logic [10:0] v_total;
      logic [10:0] vs_start;
      logic [10:0] vs_end;
      logic [10:0] v_last;
   } timing_t;

   // 0:640x480 1:800x600 2:1280x720 3:1920x1080@30 (polarity 1 = active high)
   localparam mode_t MODES [4] = '{
      '{12'd640,  12'd16, 12'd96,  12'd48,  11'd480,  11'd10, 11'd2, 11'd33, 1'b0, 1'b0, 12'd80},
      '{12'd800,  12'd40, 12'd128, 12'd88,  11'd600,  11'd1,  11'd4, 11'd23, 1'b1, 1'b1, 12'd100},
      '{12'd1280, 12'd82, 12'd80,  12'd216, 11'd720,  11'd3,  11'd5, 11'd22, 1'b1, 1'b1, 12'd160},
      '{12'd1920, 12'd88, 12'd44,  12'd148, 11'd1080, 11'd4,  11'd5, 11'd36, 1'b1, 1'b1, 12'd240}
   };

   function automatic timing_t derive(mode_t m);
      timing_t t;
      t.hs_start = m.h_active + m.h_fp;
      t.hs_end   = t.hs_start + m.h_sync;
      t.h_total  = t.hs_end + m.h_bp;
      t.h_last   = t.h_total - 12'd1;
      t.bar_last = m.bar_w - 12'd1;
      t.vs_start = m.v_active + m.v_fp;
      t.vs_end   = t.vs_start + m.v_sync;
      t.v_total  = t.vs_end + m.v_bp;
      t.v_last   = t.v_total - 11'd1;
      return t;
   endfunction

   // Totals: 800x525, 1056x628, 1658x750, 2200x1125
   localparam timing_t TIMING [4] = '{
      derive(MODES[0]), derive(MODES[1]), derive(MODES[2]), derive(MODES[3])
   };

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrap counter with runtime limit, used for both screen axes
module vga_axis_counter #(
   parameter int C_bits = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   input  logic [C_bits-1:0] limit,
   output logic [C_bits-1:0] count,
   output logic              wrap
);

   assign wrap = (count == limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= wrap ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/vga_timing_multimode.sv
// rtl/vga_timing_multimode.sv - multi-mode VGA timing generator, mode switch at frame boundary
// Optional colour bars when VGA_TEST_PICTURE_EN is defined.
module vga_timing_multimode
   import vga_timing_pkg::*;
#(
   parameter int C_modes        = 4,
   parameter int C_default_mode = 2,
   parameter int C_bits_x       = 12,
   parameter int C_bits_y       = 11
) (
   input  logic                clk_pixel,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [1:0]          mode_req,
   output logic [1:0]          mode_active,
   output logic                mode_ack,
   output logic                mode_err,
   output logic [C_bits_x-1:0] out_x,
   output logic [C_bits_y-1:0] out_y,
   output logic                vga_hsync,
   output logic                vga_vsync,
   output logic                vga_blank,
   output logic                frame_start,
   output logic [7:0]          vga_r,
   output logic [7:0]          vga_g,
   output logic [7:0]          vga_b
);

   localparam logic [1:0] DEF_MODE = 2'(C_default_mode);
   localparam logic [2:0] MODE_LIM = 3'(C_modes);

   logic [1:0]          mode_cur, pend_mode, req_q, mode_nxt, pend_mode_nxt;
   logic                pend_valid, pend_valid_nxt, ack_pend, apply, req_bad;
   logic [C_bits_x-1:0] x;
   logic [C_bits_y-1:0] y;
   logic                x_wrap, y_wrap, hs_on, vs_on, active;

   vga_axis_counter #(.C_bits(C_bits_x)) u_x_cnt (
      .clk   (clk_pixel),
      .rst_n (rst_n),
      .clr   (!enable),
      .inc   (1'b1),
      .limit (C_bits_x'(TIMING[mode_cur].h_last)),
      .count (x),
      .wrap  (x_wrap)
   );

   vga_axis_counter #(.C_bits(C_bits_y)) u_y_cnt (
      .clk   (clk_pixel),
      .rst_n (rst_n),
      .clr   (!enable),
      .inc   (x_wrap),
      .limit (C_bits_y'(TIMING[mode_cur].v_last)),
      .count (y),
      .wrap  (y_wrap)
   );

   // Pending request is compared against the mode in force after this cycle's switch.
   always_comb begin
      req_bad        = ({1'b0, mode_req} >= MODE_LIM);
      apply          = pend_valid && (!enable || (x_wrap && y_wrap));
      mode_nxt       = apply ? pend_mode : mode_cur;
      pend_valid_nxt = pend_valid && !apply;
      pend_mode_nxt  = pend_mode;
      if (!req_bad) begin
         pend_valid_nxt = (mode_req != mode_nxt);
         pend_mode_nxt  = mode_req;
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         mode_cur   <= DEF_MODE;
         pend_mode  <= DEF_MODE;
         pend_valid <= 1'b0;
         req_q      <= DEF_MODE;
         ack_pend   <= 1'b0;
      end else begin
         mode_cur   <= mode_nxt;
         pend_mode  <= pend_mode_nxt;
         pend_valid <= pend_valid_nxt;
         req_q      <= mode_req;
         if (apply)
            ack_pend <= 1'b1;
         else if (enable)
            ack_pend <= 1'b0;
      end
   end

   always_comb begin
      hs_on  = (x >= C_bits_x'(TIMING[mode_cur].hs_start)) && (x < C_bits_x'(TIMING[mode_cur].hs_end));
      vs_on  = (y >= C_bits_y'(TIMING[mode_cur].vs_start)) && (y < C_bits_y'(TIMING[mode_cur].vs_end));
      active = (x < C_bits_x'(MODES[mode_cur].h_active)) && (y < C_bits_y'(MODES[mode_cur].v_active));
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         mode_active <= DEF_MODE;
         mode_ack    <= 1'b0;
         mode_err    <= 1'b0;
         frame_start <= 1'b0;
         out_x       <= '0;
         out_y       <= '0;
         vga_blank   <= 1'b1;
         vga_hsync   <= ~MODES[C_default_mode].hpol;
         vga_vsync   <= ~MODES[C_default_mode].vpol;
      end else begin
         mode_active <= mode_cur;
         mode_ack    <= enable && ack_pend;
         mode_err    <= req_bad && (mode_req != req_q);
         frame_start <= enable && (x == '0) && (y == '0);
         out_x       <= enable ? x : '0;
         out_y       <= enable ? y : '0;
         vga_blank   <= !(enable && active);
         vga_hsync   <= (enable && hs_on) ? MODES[mode_cur].hpol : ~MODES[mode_cur].hpol;
         vga_vsync   <= (enable && vs_on) ? MODES[mode_cur].vpol : ~MODES[mode_cur].vpol;
      end
   end

`ifdef VGA_TEST_PICTURE_EN
   logic [C_bits_x-1:0] bar_cnt;
   logic [2:0]          bar_idx;

   // Bar position tracks the x counter, so colour shares the 1-cycle output latency.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (!enable || x_wrap) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (bar_cnt == C_bits_x'(TIMING[mode_cur].bar_last)) begin
         bar_cnt <= '0;
         bar_idx <= bar_idx + 3'd1;
      end else begin
         bar_cnt <= bar_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n)
         {vga_r, vga_g, vga_b} <= '0;
      else if (enable && active)
         {vga_r, vga_g, vga_b} <= {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      else
         {vga_r, vga_g, vga_b} <= '0;
   end
`else
   assign vga_r = '0;
   assign vga_g = '0;
   assign vga_b = '0;
`endif

endmodule
